// File: rtl/sudoku_puzzle_loader_if.sv
// Value stream from the puzzle source into the loader.
// valid/ready handshake, with last marking the end of a short stream.
interface sudoku_puzzle_loader_if #(
  parameter int VAL_W = 4
) ();
  logic             valid;
  logic             ready;
  logic [VAL_W-1:0] value;
  logic             last;

  modport master (output valid, output value, output last, input ready);
  modport slave  (input valid, input value, input last, output ready);
endinterface

// File: rtl/sudoku_puzzle_loader.sv
// Clears the board, streams checked givens into board memory, kicks the solver
// and records its outcome. Grid edge N = BOX*BOX.
module sudoku_puzzle_loader #(
  parameter int BOX   = 3,
  parameter int N     = BOX * BOX,
  parameter int CELLS = N * N,
  parameter int IDX_W = $clog2(CELLS),
  parameter int VAL_W = $clog2(N + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_start,
  input  logic                   i_abort,
  sudoku_puzzle_loader_if.slave  s_in,
  output logic                   o_mem_sel,
  output logic                   o_mem_write_en,
  output logic [IDX_W-1:0]       o_mem_cell_idx,
  output logic [VAL_W-1:0]       o_mem_data_in,
  output logic                   o_solver_start,
  input  logic                   i_solver_done,
  input  logic                   i_solver_unsol,
  output logic                   o_busy,
  output logic [2:0]             o_status,
  output logic [IDX_W:0]         o_givens_cnt
);

  localparam int RC_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_N    = IDX_W'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [RC_W-1:0]  BOX_R    = RC_W'(BOX);
  localparam logic [VAL_W-1:0] VAL_N    = VAL_W'(N);
  localparam logic [N-1:0]     ONE_BIT  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT, S_ERR
  } state_t;

  state_t           r_state, w_state_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [N-1:0]     r_row_mask [N];
  logic [N-1:0]     r_col_mask [N];
  logic [N-1:0]     r_box_mask [N];
  logic [N-1:0]     w_row_mask_n [N];
  logic [N-1:0]     w_col_mask_n [N];
  logic [N-1:0]     w_box_mask_n [N];
  logic             r_in_ready, w_in_ready_n;
  logic             r_mem_sel, w_mem_sel_n;
  logic             r_mem_we, w_mem_we_n;
  logic [IDX_W-1:0] r_mem_idx, w_mem_idx_n;
  logic [VAL_W-1:0] r_mem_data, w_mem_data_n;
  logic             r_start, w_start_n;
  logic             r_busy, w_busy_n;
  logic [2:0]       r_status, w_status_n;
  logic [IDX_W:0]   r_givens, w_givens_n;

  logic [RC_W-1:0]  w_row, w_col, w_box;
  logic [N-1:0]     w_vbit;
  logic             w_hs, w_range_err, w_conflict, w_final;

  // Row/column/box of the cell currently being loaded, and the one-hot of the incoming value.
  always_comb begin
    w_row       = RC_W'(r_idx / IDX_N);
    w_col       = RC_W'(r_idx % IDX_N);
    w_box       = RC_W'((w_row / BOX_R) * BOX_R + w_col / BOX_R);
    w_hs        = s_in.valid & r_in_ready;
    w_range_err = (s_in.value > VAL_N);
    w_vbit      = '0;
    if ((s_in.value != '0) && !w_range_err) begin
      w_vbit = ONE_BIT << (s_in.value - 1'b1);
    end
    w_conflict  = |(w_vbit & (r_row_mask[w_row] | r_col_mask[w_col] | r_box_mask[w_box]));
    w_final     = s_in.last || (r_idx == LAST_IDX);
  end

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_row_mask_n = r_row_mask;
    w_col_mask_n = r_col_mask;
    w_box_mask_n = r_box_mask;
    w_in_ready_n = r_in_ready;
    w_mem_sel_n  = r_mem_sel;
    w_mem_we_n   = 1'b0;
    w_mem_idx_n  = '0;
    w_mem_data_n = '0;
    w_start_n    = 1'b0;
    w_status_n   = r_status;
    w_givens_n   = r_givens;

    case (r_state)
      S_IDLE: begin
        if (i_load_start) begin
          w_state_n   = S_CLEAR;
          w_idx_n     = '0;
          w_mem_sel_n = 1'b1;
          w_status_n  = 3'd0;
          w_givens_n  = '0;
        end
      end
      S_CLEAR: begin
        w_mem_we_n  = 1'b1;
        w_mem_idx_n = r_idx;
        for (int i = 0; i < N; i++) begin
          w_row_mask_n[i] = '0;
          w_col_mask_n[i] = '0;
          w_box_mask_n[i] = '0;
        end
        if (r_idx == LAST_IDX) begin
          w_state_n    = S_LOAD;
          w_idx_n      = '0;
          w_in_ready_n = 1'b1;
        end else begin
          w_idx_n = r_idx + 1'b1;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          if (w_range_err || w_conflict) begin
            w_status_n   = w_range_err ? 3'd3 : 3'd4;
            w_state_n    = S_ERR;
            w_in_ready_n = 1'b0;
          end else begin
            w_mem_we_n   = 1'b1;
            w_mem_idx_n  = r_idx;
            w_mem_data_n = s_in.value;
            if (w_vbit != '0) begin
              w_row_mask_n[w_row] = r_row_mask[w_row] | w_vbit;
              w_col_mask_n[w_col] = r_col_mask[w_col] | w_vbit;
              w_box_mask_n[w_box] = r_box_mask[w_box] | w_vbit;
              w_givens_n          = r_givens + 1'b1;
            end
            if (w_final) begin
              w_state_n    = S_START;
              w_in_ready_n = 1'b0;
            end else begin
              w_idx_n = r_idx + 1'b1;
            end
          end
        end
      end
      S_START: begin
        w_mem_sel_n = 1'b0;
        w_start_n   = 1'b1;
        w_state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (i_solver_done) begin
          w_status_n = 3'd1;
          w_state_n  = S_IDLE;
        end else if (i_solver_unsol) begin
          w_status_n = 3'd2;
          w_state_n  = S_IDLE;
        end
      end
      S_ERR: begin
        w_mem_sel_n = 1'b0;
        w_state_n   = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Abort overrides everything decided above, in every state.
    if (i_abort) begin
      w_state_n    = S_IDLE;
      w_idx_n      = '0;
      w_in_ready_n = 1'b0;
      w_mem_sel_n  = 1'b0;
      w_mem_we_n   = 1'b0;
      w_mem_idx_n  = '0;
      w_mem_data_n = '0;
      w_start_n    = 1'b0;
      w_status_n   = 3'd5;
    end

    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      for (int i = 0; i < N; i++) begin
        r_row_mask[i] <= '0;
        r_col_mask[i] <= '0;
        r_box_mask[i] <= '0;
      end
      r_in_ready <= 1'b0;
      r_mem_sel  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_idx  <= '0;
      r_mem_data <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_status   <= 3'd0;
      r_givens   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_row_mask <= w_row_mask_n;
      r_col_mask <= w_col_mask_n;
      r_box_mask <= w_box_mask_n;
      r_in_ready <= w_in_ready_n;
      r_mem_sel  <= w_mem_sel_n;
      r_mem_we   <= w_mem_we_n;
      r_mem_idx  <= w_mem_idx_n;
      r_mem_data <= w_mem_data_n;
      r_start    <= w_start_n;
      r_busy     <= w_busy_n;
      r_status   <= w_status_n;
      r_givens   <= w_givens_n;
    end
  end

  assign s_in.ready     = r_in_ready;
  assign o_mem_sel      = r_mem_sel;
  assign o_mem_write_en = r_mem_we;
  assign o_mem_cell_idx = r_mem_idx;
  assign o_mem_data_in  = r_mem_data;
  assign o_solver_start = r_start;
  assign o_busy         = r_busy;
  assign o_status       = r_status;
  assign o_givens_cnt   = r_givens;

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Directed bench for sudoku_puzzle_loader: a BOX=3 instance for the main scenarios
// and a BOX=2 instance for the small-grid run.
module tb_sudoku_puzzle_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic       loadA, abortA, doneA, unsolA;
  logic       memSelA, memWeA, startA, busyA;
  logic [6:0] memIdxA;
  logic [3:0] memDataA;
  logic [2:0] statusA;
  logic [7:0] givensA;

  logic       loadB, abortB, doneB, unsolB;
  logic       memSelB, memWeB, startB, busyB;
  logic [3:0] memIdxB;
  logic [2:0] memDataB;
  logic [2:0] statusB;
  logic [4:0] givensB;

  sudoku_puzzle_loader_if #(.VAL_W(4)) ifA ();
  sudoku_puzzle_loader_if #(.VAL_W(3)) ifB ();

  sudoku_puzzle_loader #(.BOX(3)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_load_start(loadA), .i_abort(abortA),
    .s_in(ifA), .o_mem_sel(memSelA), .o_mem_write_en(memWeA),
    .o_mem_cell_idx(memIdxA), .o_mem_data_in(memDataA), .o_solver_start(startA),
    .i_solver_done(doneA), .i_solver_unsol(unsolA), .o_busy(busyA),
    .o_status(statusA), .o_givens_cnt(givensA)
  );

  sudoku_puzzle_loader #(.BOX(2)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_load_start(loadB), .i_abort(abortB),
    .s_in(ifB), .o_mem_sel(memSelB), .o_mem_write_en(memWeB),
    .o_mem_cell_idx(memIdxB), .o_mem_data_in(memDataB), .o_solver_start(startB),
    .i_solver_done(doneB), .i_solver_unsol(unsolB), .o_busy(busyB),
    .o_status(statusB), .o_givens_cnt(givensB)
  );

  int vectors = 0;
  int miscompares = 0;
  int wrA = 0, stA = 0, hsA = 0;
  int wrB = 0, stB = 0, hsB = 0;
  int boardA [81];
  int boardB [16];

  // Board-memory model and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (memWeA) begin wrA++; boardA[memIdxA] = int'(memDataA); end
    if (startA) stA++;
    if (ifA.valid && ifA.ready) hsA++;
    if (memWeB) begin wrB++; boardB[memIdxB] = int'(memDataB); end
    if (startB) stB++;
    if (ifB.valid && ifB.ready) hsB++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input int v, input bit last, output bit ok);
    if (!sel) begin ifA.valid = 1'b1; ifA.value = 4'(v); ifA.last = last; end
    else      begin ifB.valid = 1'b1; ifB.value = 3'(v); ifB.last = last; end
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if ((!sel && ifA.ready) || (sel && ifB.ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!sel) begin ifA.valid = 1'b0; ifA.last = 1'b0; end
    else      begin ifB.valid = 1'b0; ifB.last = 1'b0; end
  endtask

  task automatic streamValues(input bit sel, input int vals[$], input bit lastOnFinal);
    bit ok;
    bit allOk = 1'b1;
    foreach (vals[i]) begin
      applyStimulus(sel, vals[i], lastOnFinal && (i == vals.size() - 1), ok);
      allOk &= ok;
    end
    checkOutput("stream handshakes completed", 32'(allOk), 32'd1);
  endtask

  task automatic pulseLoad(input bit sel);
    if (!sel) loadA = 1'b1; else loadB = 1'b1;
    @(posedge clk); #1;
    loadA = 1'b0; loadB = 1'b0;
  endtask

  task automatic waitStart(input bit sel);
    bit seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if ((!sel && startA) || (sel && startB)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("solver_start seen", 32'(seen), 32'd1);
  endtask

  task automatic finishSolver(input bit sel, input bit done, input bit unsol);
    if (!sel) begin doneA = done; unsolA = unsol; end
    else      begin doneB = done; unsolB = unsol; end
    @(posedge clk); #1;
    doneA = 1'b0; unsolA = 1'b0; doneB = 1'b0; unsolB = 1'b0;
  endtask

  task automatic waitIdleA();
    bit idle = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!busyA) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput("return to idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int q[$];
    int grid[$];
    int w0, s0, h0;

    rstN = 1'b0;
    loadA = 0; abortA = 0; doneA = 0; unsolA = 0;
    loadB = 0; abortB = 0; doneB = 0; unsolB = 0;
    ifA.valid = 0; ifA.value = '0; ifA.last = 0;
    ifB.valid = 0; ifB.value = '0; ifB.last = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset status", 32'(statusA), 32'd0);
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset mem_sel", 32'(memSelA), 32'd0);
    checkOutput("reset in_ready", 32'(ifA.ready), 32'd0);
    checkOutput("reset givens", 32'(givensA), 32'd0);
    checkOutput("reset start", 32'(startA), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: short stream ended by in_last, solver reports solved.
    w0 = wrA; s0 = stA; h0 = hsA;
    pulseLoad(0);
    checkOutput("t1 busy after load_start", 32'(busyA), 32'd1);
    checkOutput("t1 mem_sel after load_start", 32'(memSelA), 32'd1);
    q = {5, 3, 0, 0, 7, 0, 0, 0, 0, 6, 0, 0, 1, 9, 5, 0, 0, 0};
    streamValues(0, q, 1'b1);
    checkOutput("t1 in_ready drops after last", 32'(ifA.ready), 32'd0);
    waitStart(0);
    checkOutput("t1 mem_sel released at start", 32'(memSelA), 32'd0);
    finishSolver(0, 1'b1, 1'b0);
    checkOutput("t1 status solved", 32'(statusA), 32'd1);
    checkOutput("t1 busy cleared", 32'(busyA), 32'd0);
    checkOutput("t1 write count", 32'(wrA - w0), 32'd99);
    checkOutput("t1 start pulses", 32'(stA - s0), 32'd1);
    checkOutput("t1 handshakes", 32'(hsA - h0), 32'd18);
    checkOutput("t1 givens", 32'(givensA), 32'd7);
    checkOutput("t1 cell 4", 32'(boardA[4]), 32'd7);
    checkOutput("t1 cell 13", 32'(boardA[13]), 32'd9);

    // Scenario 2: out-of-range value at index 4.
    w0 = wrA; s0 = stA; h0 = hsA;
    pulseLoad(0);
    q = {1, 2, 3, 4, 10};
    streamValues(0, q, 1'b0);
    checkOutput("t2 status range", 32'(statusA), 32'd3);
    checkOutput("t2 in_ready low", 32'(ifA.ready), 32'd0);
    waitIdleA();
    checkOutput("t2 write count", 32'(wrA - w0), 32'd85);
    checkOutput("t2 cell 4 cleared only", 32'(boardA[4]), 32'd0);
    checkOutput("t2 cell 3", 32'(boardA[3]), 32'd4);
    checkOutput("t2 no start", 32'(stA - s0), 32'd0);
    checkOutput("t2 mem_sel released", 32'(memSelA), 32'd0);
    checkOutput("t2 status held", 32'(statusA), 32'd3);

    // Scenario 3: duplicate in row (idx 1), column (idx 9), box (idx 10).
    for (int k = 0; k < 3; k++) begin
      s0 = stA;
      q = {5};
      for (int z = 0; z < ((k == 0) ? 0 : ((k == 1) ? 8 : 9)); z++) q.push_back(0);
      q.push_back(5);
      pulseLoad(0);
      streamValues(0, q, 1'b0);
      checkOutput($sformatf("t3 conflict status case%0d", k), 32'(statusA), 32'd4);
      waitIdleA();
      checkOutput($sformatf("t3 givens case%0d", k), 32'(givensA), 32'd1);
      checkOutput($sformatf("t3 no start case%0d", k), 32'(stA - s0), 32'd0);
    end

    // Scenario 4: full 81-value grid, valid held high afterwards.
    grid = {};
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid.push_back(((r * 3 + r / 3 + c) % 9) + 1);
    w0 = wrA; h0 = hsA;
    pulseLoad(0);
    streamValues(0, grid, 1'b0);
    ifA.valid = 1'b1;
    ifA.value = 4'd1;
    waitStart(0);
    finishSolver(0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4 handshakes", 32'(hsA - h0), 32'd81);
    checkOutput("t4 in_ready idle", 32'(ifA.ready), 32'd0);
    ifA.valid = 1'b0;
    checkOutput("t4 givens", 32'(givensA), 32'd81);
    checkOutput("t4 write count", 32'(wrA - w0), 32'd162);
    checkOutput("t4 cell 80", 32'(boardA[80]), 32'(grid[80]));
    checkOutput("t4 status", 32'(statusA), 32'd1);

    // Scenario 5: abort mid-clear, then reset mid-load, then a normal run.
    pulseLoad(0);
    repeat (10) @(posedge clk);
    #1;
    abortA = 1'b1;
    @(posedge clk); #1;
    abortA = 1'b0;
    checkOutput("t5 abort status", 32'(statusA), 32'd5);
    checkOutput("t5 abort busy", 32'(busyA), 32'd0);
    checkOutput("t5 abort mem_sel", 32'(memSelA), 32'd0);
    checkOutput("t5 abort write_en", 32'(memWeA), 32'd0);
    pulseLoad(0);
    q = {1, 2};
    streamValues(0, q, 1'b0);
    checkOutput("t5 loading ready", 32'(ifA.ready), 32'd1);
    rstN = 1'b0;
    #2;
    checkOutput("t5 reset status", 32'(statusA), 32'd0);
    checkOutput("t5 reset busy", 32'(busyA), 32'd0);
    checkOutput("t5 reset mem_sel", 32'(memSelA), 32'd0);
    checkOutput("t5 reset ready", 32'(ifA.ready), 32'd0);
    checkOutput("t5 reset givens", 32'(givensA), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    pulseLoad(0);
    q = {9};
    streamValues(0, q, 1'b1);
    waitStart(0);
    finishSolver(0, 1'b1, 1'b0);
    checkOutput("t5 rerun status", 32'(statusA), 32'd1);
    checkOutput("t5 rerun givens", 32'(givensA), 32'd1);

    // Scenario 6: BOX=2 instance, full puzzle, solver says unsolvable.
    w0 = wrB; s0 = stB; h0 = hsB;
    pulseLoad(1);
    q = {1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
    streamValues(1, q, 1'b1);
    waitStart(1);
    checkOutput("t6 mem_sel released", 32'(memSelB), 32'd0);
    finishSolver(1, 1'b0, 1'b1);
    checkOutput("t6 status unsolvable", 32'(statusB), 32'd2);
    checkOutput("t6 busy", 32'(busyB), 32'd0);
    checkOutput("t6 write count", 32'(wrB - w0), 32'd32);
    checkOutput("t6 handshakes", 32'(hsB - h0), 32'd16);
    checkOutput("t6 start pulses", 32'(stB - s0), 32'd1);
    checkOutput("t6 givens", 32'(givensB), 32'd16);
    checkOutput("t6 cell 5", 32'(boardB[5]), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
